misc_pwm_ctrl: RTL and testbench

- Clocked, parametrised successor to the combinational misc-LED gate.
- Drives the non-seven-segment indicator LEDs with a true PWM at a programmable brightness.
- Soft-ramps brightness on display on/off transitions.
- Qualifies the GPS-lock indicator so it lights only after GPS has been continuously good for a set number of PWM periods.
- Sits between the display-control logic (on, duty) and the LED pins.

---
 rtl/misc_pwm_ctrl.sv | 169 ++++++++++++++++
 tb/tb_misc_pwm_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/misc_pwm_ctrl.sv
// rtl/misc_pwm_ctrl.sv - PWM driver for misc indicator LEDs with soft ramp and GPS-lock qualification
// Optional blinking of the lock LED while unlocked: define MISC_PWM_BLINK_EN.
module misc_pwm_ctrl #(
    parameter int NUM_LEDS     = 5,
    parameter int PWM_BITS     = 8,
    parameter int RAMP_PERIODS = 4,
    parameter int LOCK_QUAL    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on,
    input  logic                gps_lost,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [NUM_LEDS-1:0] led_mask,
    output logic [NUM_LEDS-1:0] misc_leds,
    output logic                gps_lock
);

    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
    localparam int                  RDW       = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [RDW-1:0]      RAMP_LAST = RDW'((RAMP_PERIODS > 0) ? RAMP_PERIODS - 1 : 0);
    localparam logic [7:0]          QUAL_MAX  = 8'(LOCK_QUAL);

    typedef enum logic [1:0] {
        OFF,
        RAMP,
        STEADY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] bright;
    logic [PWM_BITS-1:0] bright_nxt;
    logic [PWM_BITS-1:0] bright_step;
    logic [PWM_BITS-1:0] target;
    logic [RDW-1:0]      ramp_div;
    logic [RDW-1:0]      ramp_div_nxt;
    logic [7:0]          qual;
    logic                period_end;
    logic                pwm_raw;
    logic                locked;
    logic                lock_drive;

    assign period_end = (cnt == PWM_MAX);
    assign target     = on ? duty : '0;
    assign pwm_raw    = (level == PWM_MAX) || (cnt < level);
    assign locked     = (qual == QUAL_MAX);

    // Brightness ramp: next state, next brightness and period divider, only moving at period end
    always_comb begin
        state_nxt    = state;
        bright_nxt   = bright;
        ramp_div_nxt = ramp_div;
        bright_step  = bright;
        if (bright < target) begin
            bright_step = bright + 1'b1;
        end else if (bright > target) begin
            bright_step = bright - 1'b1;
        end
        if (period_end) begin
            if (RAMP_PERIODS == 0) begin
                bright_nxt   = target;
                ramp_div_nxt = '0;
                state_nxt    = (target == '0) ? OFF : STEADY;
            end else begin
                case (state)
                    OFF: begin
                        bright_nxt   = '0;
                        ramp_div_nxt = '0;
                        if (target != '0) begin
                            state_nxt = RAMP;
                        end
                    end
                    RAMP: begin
                        if (ramp_div == RAMP_LAST) begin
                            ramp_div_nxt = '0;
                            bright_nxt   = bright_step;
                            if (bright_step == target) begin
                                state_nxt = (target == '0) ? OFF : STEADY;
                            end
                        end else begin
                            ramp_div_nxt = ramp_div + 1'b1;
                        end
                    end
                    STEADY: begin
                        if (target != bright) begin
                            state_nxt    = RAMP;
                            ramp_div_nxt = '0;
                        end
                    end
                    default: begin
                        state_nxt    = OFF;
                        bright_nxt   = '0;
                        ramp_div_nxt = '0;
                    end
                endcase
            end
        end
    end

    // State register: ramp state, PWM counter, and the period-aligned level actually driven
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= OFF;
            bright   <= '0;
            ramp_div <= '0;
            cnt      <= '0;
            level    <= '0;
        end else begin
            state    <= state_nxt;
            bright   <= bright_nxt;
            ramp_div <= ramp_div_nxt;
            cnt      <= cnt + 1'b1;
            if (period_end) begin
                level <= bright_nxt;
            end
        end
    end

    // Lock qualifier: count clean periods, any loss or display-off restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qual <= '0;
        end else if (gps_lost || !on) begin
            qual <= '0;
        end else if (period_end && !locked) begin
            qual <= qual + 8'd1;
        end
    end

`ifdef MISC_PWM_BLINK_EN
    logic [PWM_BITS-2:0] blink_cnt;
    logic                blink;

    // Blink toggle for the unlocked indicator, flipping once per full wrap of the period counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (!on) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (period_end) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) begin
                blink <= ~blink;
            end
        end
    end

    assign lock_drive = on && ((locked && !gps_lost) || blink) && pwm_raw;
`else
    assign lock_drive = on && locked && !gps_lost && pwm_raw;
`endif

    // Output registers: masked PWM for the misc LEDs and the dimmed lock indicator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misc_leds <= '0;
            gps_lock  <= 1'b0;
        end else begin
            misc_leds <= {NUM_LEDS{pwm_raw}} & led_mask;
            gps_lock  <= lock_drive;
        end
    end

endmodule

// File: tb/tb_misc_pwm_ctrl.sv
// tb/tb_misc_pwm_ctrl.sv - period scoreboard bench for misc_pwm_ctrl
module tb_misc_pwm_ctrl;

    logic       clk;
    logic       reset;
    logic       on;
    logic       gps_lost;
    logic [3:0] duty;
    logic [4:0] led_mask;
    logic [4:0] misc_leds;
    logic       gps_lock;
    logic [4:0] r_leds;
    logic       r_lock;

    misc_pwm_ctrl #(.NUM_LEDS(5), .PWM_BITS(4), .RAMP_PERIODS(0), .LOCK_QUAL(3)) dut (
        .clk(clk), .reset(reset), .on(on), .gps_lost(gps_lost), .duty(duty),
        .led_mask(led_mask), .misc_leds(misc_leds), .gps_lock(gps_lock)
    );

    misc_pwm_ctrl #(.NUM_LEDS(5), .PWM_BITS(4), .RAMP_PERIODS(2), .LOCK_QUAL(3)) dut_r (
        .clk(clk), .reset(reset), .on(on), .gps_lost(gps_lost), .duty(duty),
        .led_mask(led_mask), .misc_leds(r_leds), .gps_lock(r_lock)
    );

    typedef struct {
        int hc;
        int patt;
        int lock_hc;
        int r_hc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pcount;
    int   prev_target = 0;
    int   streak = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) pcount <= 0;
        else       pcount <= pcount + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int ramp_up(input int rel);
        if (rel < 3) return 0;
        return ((rel - 1) / 2 > 3) ? 3 : (rel - 1) / 2;
    endfunction

    function automatic int ramp_dn(input int rel);
        if (rel < 3) return 3;
        return (3 - (rel - 1) / 2 < 0) ? 0 : 3 - (rel - 1) / 2;
    endfunction

    // One PWM period of stimulus; pushes what this period's output window must look like
    task automatic run_period(input logic p_on, input logic [3:0] p_duty, input logic [4:0] p_mask,
                              input logic p_lost, input int r_exp, input int chg_at,
                              input logic [3:0] chg_duty, input int pulse_at);
        exp_t e;
        e.hc      = (prev_target == 15) ? 16 : prev_target;
        e.patt    = (prev_target != 0) ? int'(p_mask) : 0;
        e.lock_hc = (pulse_at >= 0) ? -1 : ((p_on && !p_lost && streak >= 3) ? e.hc : 0);
`ifdef MISC_PWM_BLINK_EN
        if (p_on && !(!p_lost && streak >= 3)) e.lock_hc = -1;
`endif
        e.r_hc = r_exp;
        exp_q.push_back(e);
        on       = p_on;
        duty     = p_duty;
        led_mask = p_mask;
        gps_lost = p_lost;
        for (int i = 0; i < 16; i++) begin
            if (i == chg_at) duty = chg_duty;
            if (pulse_at >= 0 && i == pulse_at) begin
                check_eq("lock_before_pulse", int'(gps_lock), 1);
                gps_lost = 1'b1;
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                check_eq("lock_drop_after_pulse", int'(gps_lock), 0);
                gps_lost = 1'b0;
            end
            @(negedge clk);
        end
        prev_target = p_on ? int'(duty) : 0;
        if (pulse_at >= 0)         streak = 1;
        else if (p_on && !p_lost)  streak = (streak < 3) ? streak + 1 : 3;
        else                       streak = 0;
    endtask

    // Monitor: collect one output window per PWM period and compare with the queued expectation
    initial begin
        int         idx, hc, lhc, rhc, patt;
        logic [4:0] first_v;
        logic       bad;
        exp_t       e;
        hc = 0; lhc = 0; rhc = 0; patt = 0; first_v = '0; bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && pcount > 0) begin
                idx = (pcount - 1) % 16;
                if (idx == 0) begin
                    hc = 0; lhc = 0; rhc = 0; patt = 0; first_v = '0; bad = 1'b0;
                end
                if (misc_leds != '0) begin
                    if (idx != hc) bad = 1'b1;
                    if (hc == 0) first_v = misc_leds;
                    else if (misc_leds != first_v) bad = 1'b1;
                    patt = patt | int'(misc_leds);
                    hc++;
                end
                if (gps_lock) lhc++;
                if (r_leds != '0) rhc++;
                if (idx == 15 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("leds_high_clks", bad ? -1 : hc, e.hc);
                    check_eq("leds_pattern", patt, e.patt);
                    if (e.lock_hc >= 0) check_eq("lock_high_clks", lhc, e.lock_hc);
                    if (e.r_hc >= 0) check_eq("ramp_high_clks", rhc, e.r_hc);
                end
            end
        end
    end

    // Driver: reset, ramp, PWM boundaries, glitch-free duty change, lock qualification
    initial begin
        reset = 1'b1; on = 1'b0; gps_lost = 1'b0; duty = '0; led_mask = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_leds", int'(misc_leds), 0);
        check_eq("reset_lock", int'(gps_lock), 0);
        check_eq("reset_ramp_leds", int'(r_leds), 0);
        reset = 1'b0;

        for (int w = 0; w < 10; w++) run_period(1, 4'd3, 5'h1f, 0, ramp_up(w), -1, 4'd0, -1);
        for (int w = 0; w < 9; w++)  run_period(0, 4'd3, 5'h1f, 0, ramp_dn(w), -1, 4'd0, -1);

        for (int w = 0; w < 3; w++) run_period(1, 4'd4, 5'h1f, 0, -1, -1, 4'd0, -1);
        for (int w = 0; w < 2; w++) run_period(1, 4'd0, 5'h1f, 0, -1, -1, 4'd0, -1);
        for (int w = 0; w < 2; w++) run_period(1, 4'd15, 5'h1f, 0, -1, -1, 4'd0, -1);
        for (int w = 0; w < 2; w++) run_period(1, 4'd4, 5'b00101, 0, -1, -1, 4'd0, -1);
        run_period(1, 4'd4, 5'h1f, 0, -1, -1, 4'd0, -1);
        run_period(1, 4'd4, 5'h1f, 0, -1, 7, 4'd10, -1);
        for (int w = 0; w < 2; w++) run_period(1, 4'd10, 5'h1f, 0, -1, -1, 4'd0, -1);

        for (int w = 0; w < 4; w++) run_period(1, 4'd15, 5'h1f, 0, -1, -1, 4'd0, -1);
        run_period(1, 4'd15, 5'h1f, 0, -1, -1, 4'd0, 5);
        for (int w = 0; w < 4; w++) run_period(1, 4'd15, 5'h1f, 0, -1, -1, 4'd0, -1);
        for (int w = 0; w < 17; w++) run_period(1, 4'd15, 5'h1f, 1, -1, -1, 4'd0, -1);

        repeat (2) @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        check_eq("leds_on_before_reset", int'(misc_leds), 31);
        reset = 1'b1;
        #1;
        check_eq("midrun_reset_leds", int'(misc_leds), 0);
        check_eq("midrun_reset_lock", int'(gps_lock), 0);
        check_eq("midrun_reset_ramp_leds", int'(r_leds), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
